// File: rtl/echo_cancellation_full.sv
// -----------------------------------------------------------------------------
// echo_cancellation_full
// Four-tap LMS adaptive echo canceller on 16-bit signed samples. Once per
// sample period it estimates the echo of the lagged far-end reference,
// subtracts it from the near-end sample, registers the residual and adapts
// the tap weights (Q4.20, 1.0 = 2^20).
//
// Parameters
//   MU_SHIFT   right shift of the e*x product in the weight update
//   MIN_CYCLE  smallest sampling_cycle that allows processing
//
// Ports
//   clk_operation          in   operation clock, rising edge
//   rst                    in   synchronous active-high reset
//   sig16b                 in   near-end sample (signal + echo), signed
//   sig16b_lag             in   far-end reference sample, signed
//   sampling_cycle         in   clocks per sample period
//   sampling_cycle_counter in   position within the sample period
//   enable                 in   level-sensitive processing enable
//   sig16b_without_echo    out  registered residual e, signed
//
// Build option
//   ECHO_CANCEL_SAT_EN  defined: residual output clamps to the 16-bit range;
//                       undefined: residual output is e modulo 2^16.
// -----------------------------------------------------------------------------
module echo_cancellation_full #(
  parameter int MU_SHIFT  = 8,
  parameter int MIN_CYCLE = 16
) (
  input  logic               clk_operation,
  input  logic               rst,
  input  logic signed [15:0] sig16b,
  input  logic signed [15:0] sig16b_lag,
  input  logic [12:0]        sampling_cycle,
  input  logic [12:0]        sampling_cycle_counter,
  input  logic               enable,
  output logic signed [15:0] sig16b_without_echo
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_MAC0 = 4'd2,
    ST_MAC1 = 4'd3,
    ST_MAC2 = 4'd4,
    ST_MAC3 = 4'd5,
    ST_ERR  = 4'd6,
    ST_UPD0 = 4'd7,
    ST_UPD1 = 4'd8,
    ST_UPD2 = 4'd9,
    ST_UPD3 = 4'd10
  } state_t;

  // Clamp a wide weight sum into the signed 24-bit weight range.
  function automatic logic signed [23:0] sat24(input logic signed [41:0] v);
    if (v[41:23] == {19{v[41]}}) begin
      return v[23:0];
    end else if (v[41]) begin
      return 24'h800000;
    end else begin
      return 24'h7FFFFF;
    end
  endfunction

  // Clamp the full-precision error into the signed 16-bit output range.
  function automatic logic signed [15:0] sat16(input logic signed [24:0] v);
    if (v[24:15] == {10{v[24]}}) begin
      return v[15:0];
    end else if (v[24]) begin
      return 16'h8000;
    end else begin
      return 16'h7FFF;
    end
  endfunction

  state_t             state_r, state_s;
  logic signed [15:0] x_r [4];
  logic signed [23:0] w_r [4];
  logic signed [43:0] acc_r;
  logic signed [15:0] d_r;
  logic signed [24:0] e_full_r;

  logic               strobe_s;
  logic [1:0]         tap_s;
  logic signed [15:0] x_sel_s;
  logic signed [23:0] w_sel_s;
  logic signed [39:0] mac_prod_s;
  logic signed [23:0] y_s;
  logic signed [24:0] e_full_s;
  logic signed [40:0] upd_prod_s;
  logic signed [40:0] upd_delta_s;
  logic signed [41:0] w_sum_s;
  logic signed [23:0] w_next_s;
  logic signed [15:0] e_out_s;

  assign strobe_s = enable && (sampling_cycle_counter == 13'd0) &&
                    (sampling_cycle >= 13'(MIN_CYCLE));

  // Tap index shared by the MAC and update phases.
  always_comb begin
    tap_s = 2'd0;
    case (state_r)
      ST_MAC0, ST_UPD0: tap_s = 2'd0;
      ST_MAC1, ST_UPD1: tap_s = 2'd1;
      ST_MAC2, ST_UPD2: tap_s = 2'd2;
      ST_MAC3, ST_UPD3: tap_s = 2'd3;
      default:          tap_s = 2'd0;
    endcase
  end

  // Arithmetic for MAC, error and weight update on the selected tap.
  always_comb begin
    x_sel_s     = x_r[tap_s];
    w_sel_s     = w_r[tap_s];
    mac_prod_s  = $signed({{16{w_sel_s[23]}}, w_sel_s}) *
                  $signed({{24{x_sel_s[15]}}, x_sel_s});
    // acc >>> 20; the accumulator magnitude keeps this inside 24 bits.
    y_s         = acc_r[43:20];
    e_full_s    = $signed({{9{d_r[15]}}, d_r}) - $signed({y_s[23], y_s});
    // Update uses the stored unsaturated error, not the output value.
    upd_prod_s  = $signed({{16{e_full_r[24]}}, e_full_r}) *
                  $signed({{25{x_sel_s[15]}}, x_sel_s});
    upd_delta_s = upd_prod_s >>> MU_SHIFT;
    w_sum_s     = $signed({{18{w_sel_s[23]}}, w_sel_s}) +
                  $signed({upd_delta_s[40], upd_delta_s});
    w_next_s    = sat24(w_sum_s);
`ifdef ECHO_CANCEL_SAT_EN
    e_out_s     = sat16(e_full_s);
`else
    e_out_s     = e_full_s[15:0];
`endif
  end

  // State register.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state sequencing; strobes are only looked at in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (strobe_s) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: state_s = ST_MAC0;
      ST_MAC0: state_s = ST_MAC1;
      ST_MAC1: state_s = ST_MAC2;
      ST_MAC2: state_s = ST_MAC3;
      ST_MAC3: state_s = ST_ERR;
      ST_ERR:  state_s = ST_UPD0;
      ST_UPD0: state_s = ST_UPD1;
      ST_UPD1: state_s = ST_UPD2;
      ST_UPD2: state_s = ST_UPD3;
      ST_UPD3: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath registers: delay line, accumulator, error, weights and output.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        x_r[k] <= 16'sd0;
        w_r[k] <= 24'sd0;
      end
      acc_r               <= 44'sd0;
      d_r                 <= 16'sd0;
      e_full_r            <= 25'sd0;
      sig16b_without_echo <= 16'sd0;
    end else begin
      case (state_r)
        ST_LOAD: begin
          x_r[3] <= x_r[2];
          x_r[2] <= x_r[1];
          x_r[1] <= x_r[0];
          x_r[0] <= sig16b_lag;
          d_r    <= sig16b;
          acc_r  <= 44'sd0;
        end
        ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3: begin
          acc_r <= acc_r + $signed({{4{mac_prod_s[39]}}, mac_prod_s});
        end
        ST_ERR: begin
          e_full_r            <= e_full_s;
          sig16b_without_echo <= e_out_s;
        end
        ST_UPD0, ST_UPD1, ST_UPD2, ST_UPD3: begin
          w_r[tap_s] <= w_next_s;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_cancellation_full.sv
module tb_echo_cancellation_full;

  localparam int MU = 8;

  logic               clk_operation = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sig16b = 16'sd0;
  logic signed [15:0] sig16b_lag = 16'sd0;
  logic [12:0]        sampling_cycle = 13'd100;
  logic [12:0]        sampling_cycle_counter = 13'd1;
  logic               enable = 1'b0;
  logic signed [15:0] sig16b_without_echo;

  echo_cancellation_full #(.MU_SHIFT(MU), .MIN_CYCLE(16)) dut (
    .clk_operation          (clk_operation),
    .rst                    (rst),
    .sig16b                 (sig16b),
    .sig16b_lag             (sig16b_lag),
    .sampling_cycle         (sampling_cycle),
    .sampling_cycle_counter (sampling_cycle_counter),
    .enable                 (enable),
    .sig16b_without_echo    (sig16b_without_echo)
  );

  always #5 clk_operation = ~clk_operation;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] prev_out = 16'h0000;

  // Sample-level reference: plain integer LMS on the whole filter.
  longint mw [4];
  longint mx [4];

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0;
      mx[k] = 0;
    end
  endfunction

  function automatic longint model_step(longint d, longint lag);
    longint acc, y, e, nw;
    mx[3] = mx[2]; mx[2] = mx[1]; mx[1] = mx[0]; mx[0] = lag;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += mw[k] * mx[k];
    y = acc >>> 20;
    e = d - y;
    for (int k = 0; k < 4; k++) begin
      nw = mw[k] + ((e * mx[k]) >>> MU);
      if (nw > 8388607) nw = 8388607;
      if (nw < -8388608) nw = -8388608;
      mw[k] = nw;
    end
    return e;
  endfunction

  function automatic logic [15:0] model_out(longint e);
    longint v;
    v = e;
`ifdef ECHO_CANCEL_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_operation);
    rst = 1'b1;
    sampling_cycle_counter = 13'd1;
    repeat (3) @(posedge clk_operation);
    @(negedge clk_operation);
    rst = 1'b0;
    model_reset();
    prev_out = 16'h0000;
  endtask

  // One accepted sample: strobe, then walk the 11-cycle budget. Output must
  // be unchanged after edge T+5 and hold the new residual after edge T+6.
  // ov in 1..10 re-asserts counter==0 at that busy edge (must be ignored).
  task automatic do_sample(input logic signed [15:0] d, input logic signed [15:0] lag,
                           input logic [15:0] exp, input int ov, input string nm);
    @(negedge clk_operation);
    sig16b = d;
    sig16b_lag = lag;
    enable = 1'b1;
    sampling_cycle_counter = 13'd0;
    @(posedge clk_operation);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk_operation);
      if (i == 6) check({nm, "_hold"}, sig16b_without_echo, prev_out);
      if (i == 7) check({nm, "_out"}, sig16b_without_echo, exp);
      sampling_cycle_counter = (i == ov) ? 13'd0 : 13'(i);
      @(posedge clk_operation);
    end
    prev_out = exp;
  endtask

  task automatic model_sample(input logic signed [15:0] d, input logic signed [15:0] lag,
                              input int ov, input string nm);
    logic [15:0] exp;
    exp = model_out(model_step(longint'(d), longint'(lag)));
    do_sample(d, lag, exp, ov, nm);
  endtask

  typedef struct {
    logic               do_rst;
    logic signed [15:0] d;
    logic signed [15:0] lag;
    logic signed [15:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    longint dummy;
    int o;
    tbl[0] = '{1'b1, 16'sd1000,   16'sd500,    16'sd1000};
    tbl[1] = '{1'b1, 16'sd20000,  16'sd20000,  16'sd20000};
    tbl[2] = '{1'b0, 16'sd20000,  16'sd20000, -16'sd9802};
    tbl[3] = '{1'b0, 16'sd0,      16'sd0,      16'sd14607};
    tbl[4] = '{1'b1, -16'sd32768, 16'sd123,   -16'sd32768};
    tbl[5] = '{1'b1, 16'sd32767, -16'sd32768,  16'sd32767};

    model_reset();
    repeat (3) @(posedge clk_operation);
    @(negedge clk_operation);
    rst = 1'b0;
    check("reset_out", sig16b_without_echo, 16'h0000);

    // Hand-computed vectors (fresh weights or known history).
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].do_rst) apply_reset();
      dummy = model_step(longint'(tbl[i].d), longint'(tbl[i].lag));
      do_sample(tbl[i].d, tbl[i].lag, tbl[i].exp, 0, "tbl");
    end

    // Reset mid-MAC discards the sample and clears the output.
    @(negedge clk_operation);
    sig16b = 16'sd4321; sig16b_lag = 16'sd99; sampling_cycle_counter = 13'd0;
    @(posedge clk_operation);
    @(negedge clk_operation);
    sampling_cycle_counter = 13'd1;
    repeat (2) @(posedge clk_operation);
    apply_reset();
    check("rst_mid_mac", sig16b_without_echo, 16'h0000);
    repeat (10) @(posedge clk_operation);
    @(negedge clk_operation);
    check("rst_quiet", sig16b_without_echo, 16'h0000);
    model_sample(16'sd777, 16'sd55, 0, "after_rst");

    // Reset wins over a same-cycle strobe.
    @(negedge clk_operation);
    rst = 1'b1; enable = 1'b1; sig16b = 16'sd1234; sampling_cycle_counter = 13'd0;
    @(posedge clk_operation);
    @(negedge clk_operation);
    rst = 1'b0; sampling_cycle_counter = 13'd1;
    model_reset(); prev_out = 16'h0000;
    repeat (10) @(posedge clk_operation);
    @(negedge clk_operation);
    check("rst_prio", sig16b_without_echo, 16'h0000);

    // Convergence on a constant echo path.
    sampling_cycle = 13'd4000;
    for (int s = 0; s < 1000; s++) model_sample(16'sd1000, 16'sd1000, 0, "conv");
    o = $signed(sig16b_without_echo);
    n_cmp++;
    if (o > 2 || o < -2) begin
      n_fail++;
      $display("FAIL conv_final: got %0d expected |e|<=2", o);
    end

    // Gating: enable low across counter wraps.
    @(negedge clk_operation);
    enable = 1'b0; sig16b = 16'sd5000; sig16b_lag = -16'sd3000;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk_operation);
      sampling_cycle_counter = 13'(c % 16);
    end
    @(negedge clk_operation);
    sampling_cycle_counter = 13'd1;
    check("gate_enable", sig16b_without_echo, prev_out);

    // Gating: sampling_cycle below and at the minimum.
    enable = 1'b1;
    sampling_cycle = 13'd10;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_operation);
      sampling_cycle_counter = 13'(c % 10);
    end
    sampling_cycle = 13'd15;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk_operation);
      sampling_cycle_counter = 13'(c % 15);
    end
    @(negedge clk_operation);
    sampling_cycle_counter = 13'd1;
    check("gate_min_cycle", sig16b_without_echo, prev_out);
    sampling_cycle = 13'd16;
    model_sample(16'sd1000, 16'sd1000, 0, "min16");

    // Output saturation / wrap on the converged filter.
    model_sample(16'sd32767, -16'sd32768, 0, "sat");
`ifdef ECHO_CANCEL_SAT_EN
    check("sat_clamp", sig16b_without_echo, 16'h7FFF);
`endif

    // Busy overlap: counter==0 re-asserted at every busy position.
    apply_reset();
    for (int ov = 1; ov <= 10; ov++) model_sample(16'sd1500, 16'sd700, ov, "overlap");
    model_sample(-16'sd200, 16'sd900, 0, "post_overlap");

    // Random small-reference traffic with random overlap pulses.
    apply_reset();
    for (int s = 0; s < 150; s++) begin
      model_sample(16'($urandom), 16'($signed($urandom_range(0, 8190)) - 4095),
                   int'($urandom_range(0, 10)), "rand");
    end

    // Large-amplitude burst drives the weights into saturation.
    apply_reset();
    for (int s = 0; s < 8; s++) begin
      model_sample(16'($urandom), ($urandom_range(0, 1) == 0) ? 16'sd32767 : -16'sd32767,
                   0, "burst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
